stamp_dispatcher: RTL and testbench



---
 rtl/conveyor_pkg.sv | 44 ++++
 rtl/stage_issue_fsm.sv | 119 +++++++++++
 rtl/stamp_dispatcher.sv | 111 +++++++++++
 tb/tb_stamp_dispatcher.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conveyor_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Package   : conveyor_pkg                                                |
// | Purpose   : Shared widths, stamp bit positions, command field offsets   |
// |             and stage-FSM types for the conveyor instruction chain.     |
// | Revision  : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
package conveyor_pkg;

  localparam int N_SLOTS = 8;
  localparam int CMD_W   = 88;
  localparam int TAKE_W  = 5;
  localparam int SLOT_W  = $clog2(N_SLOTS);
  localparam int N_STAGE = 3;

  // Stamp bit positions inside a slot's 3-bit stamp; also the stage index
  localparam int STAMP_EX  = 2;
  localparam int STAMP_MEM = 1;
  localparam int STAMP_WB  = 0;

  // Command word field offsets (all fields are 5 bits wide)
  localparam int FIELD_W  = 5;
  localparam int TAKE_LSB = 30;
  localparam int DEST_LSB = 67;
  localparam int SRC0_LSB = 72;
  localparam int SRC1_LSB = 77;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STAMP = 2'd3
  } stage_state_e;

  // One stage's request to write a stamp back into the chain
  typedef struct packed {
    logic              valid;
    logic [SLOT_W-1:0] idx;
    logic [2:0]        bits;
    logic [TAKE_W-1:0] take;
  } stamp_req_t;

endpackage
`default_nettype wire

// File: rtl/stage_issue_fsm.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module    : stage_issue_fsm                                             |
// | Purpose   : Issue/complete FSM for one stage unit. Latches the selected |
// |             slot, handshakes with the unit, follows the slot as the     |
// |             chain shifts and raises a stamp write request at the end.   |
// | Revision  : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
module stage_issue_fsm
  import conveyor_pkg::*;
#(
  parameter int STAGE_BIT = STAMP_EX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     advance_i,
  input  logic                     sel_valid_i,
  input  logic [SLOT_W-1:0]        sel_idx_i,
  input  logic [N_SLOTS*CMD_W-1:0] reg_out_flat_i,
  input  logic                     ack_i,
  input  logic                     done_i,
  input  logic [TAKE_W-1:0]        take_i,
  output logic                     req_o,
  output logic [CMD_W-1:0]         cmd_o,
  output logic                     busy_o,
  output stamp_req_t               stamp_o
);

  localparam logic [2:0] c_STAGE_MASK = 3'(1 << STAGE_BIT);

  stage_state_e      state_q, state_d;
  logic [SLOT_W-1:0] cur_q, cur_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [TAKE_W-1:0] take_q, take_d;
  logic [2:0]        w_slot_bits;
  logic              w_can_stamp;

  // State, tracked slot, held command and latched take
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cmd_q   <= '0;
      take_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cmd_q   <= cmd_d;
      take_q  <= take_d;
    end
  end

  // Current stamp bits of the tracked slot; slot 0 cannot be stamped
  // without a shift because the write lands in index+1.
  assign w_slot_bits = reg_out_flat_i[int'(cur_q)*CMD_W +: 3];
  assign w_can_stamp = advance_i || (cur_q != '0);

  // Next-state: selection, handshake, completion and slot tracking
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cmd_d   = cmd_q;
    take_d  = take_q;
    if (state_q != ST_IDLE && advance_i) begin
      cur_d = cur_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (sel_valid_i) begin
          state_d = ST_REQ;
          // The slot moves along with a shift on this very edge
          cur_d   = sel_idx_i + {{(SLOT_W-1){1'b0}}, advance_i};
          cmd_d   = reg_out_flat_i[int'(sel_idx_i)*CMD_W +: CMD_W];
        end
      end
      ST_REQ: begin
        if (ack_i) begin
          if (done_i) begin
            take_d  = take_i;
            state_d = ST_STAMP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (done_i) begin
          take_d  = take_i;
          state_d = ST_STAMP;
        end
      end
      ST_STAMP: begin
        if (w_can_stamp) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state, tracked slot and advance
  always_comb begin
    req_o         = (state_q == ST_REQ);
    busy_o        = (state_q != ST_IDLE);
    cmd_o         = cmd_q;
    stamp_o.valid = (state_q == ST_STAMP) && w_can_stamp;
    stamp_o.idx   = advance_i ? cur_q : (cur_q - 1'b1);
    stamp_o.bits  = w_slot_bits | c_STAGE_MASK;
    stamp_o.take  = take_q;
  end

  // The chain never shifts slot 7 out while it still owes a stamp
  a_no_shift_out : assert property (@(posedge clk) disable iff (reset)
    !(advance_i && (((state_q != ST_IDLE) && (cur_q == SLOT_W'(N_SLOTS-1))) ||
                    ((state_q == ST_IDLE) && sel_valid_i &&
                     (sel_idx_i == SLOT_W'(N_SLOTS-1))))));

endmodule
`default_nettype wire

// File: rtl/stamp_dispatcher.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module    : stamp_dispatcher                                            |
// | Purpose   : Consumer end of the conveyor chain. Picks the oldest ready  |
// |             slot for exec/mem/wb, runs one issue FSM per stage and      |
// |             merges their stamp/take write-backs into the chain ports.   |
// | Revision  : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
module stamp_dispatcher
  import conveyor_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SLOTS*3-1:0]      reg_start_flat,
  input  logic [N_SLOTS*CMD_W-1:0]  reg_out_flat,
  input  logic                      advance,
  output logic                      ex_req,
  output logic                      mem_req,
  output logic                      wb_req,
  output logic [CMD_W-1:0]          ex_cmd,
  output logic [CMD_W-1:0]          mem_cmd,
  output logic [CMD_W-1:0]          wb_cmd,
  input  logic                      ex_ack,
  input  logic                      mem_ack,
  input  logic                      wb_ack,
  input  logic                      ex_done,
  input  logic                      mem_done,
  input  logic                      wb_done,
  input  logic [TAKE_W-1:0]         ex_take,
  output logic [N_SLOTS*3-1:0]      stamp_flat,
  output logic [N_SLOTS-1:0]        stamp_in,
  output logic [N_SLOTS*TAKE_W-1:0] take_flat,
  output logic [N_SLOTS-1:0]        take_in,
  output logic [2:0]                busy
);

  // Stage vectors are indexed by stamp bit: [2]=ex, [1]=mem, [0]=wb
  logic [N_STAGE-1:0] w_ack, w_done, w_req, w_busy, w_sel_valid;
  logic [SLOT_W-1:0]  w_sel_idx [N_STAGE];
  logic [CMD_W-1:0]   w_cmd     [N_STAGE];
  stamp_req_t         w_stamp   [N_STAGE];

  assign w_ack  = {ex_ack, mem_ack, wb_ack};
  assign w_done = {ex_done, mem_done, wb_done};

  // Oldest ready slot per stage: the highest index wins
  always_comb begin
    for (int s = 0; s < N_STAGE; s++) begin
      w_sel_valid[s] = 1'b0;
      w_sel_idx[s]   = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
        if (reg_start_flat[k*3+s]) begin
          w_sel_valid[s] = 1'b1;
          w_sel_idx[s]   = SLOT_W'(k);
        end
      end
    end
  end

  generate
    for (genvar s = 0; s < N_STAGE; s++) begin : g_stage
      stage_issue_fsm #(
        .STAGE_BIT (s)
      ) u_fsm (
        .clk            (clk),
        .reset          (reset),
        .advance_i      (advance),
        .sel_valid_i    (w_sel_valid[s]),
        .sel_idx_i      (w_sel_idx[s]),
        .reg_out_flat_i (reg_out_flat),
        .ack_i          (w_ack[s]),
        .done_i         (w_done[s]),
        .take_i         ((s == STAMP_EX) ? ex_take : {TAKE_W{1'b0}}),
        .req_o          (w_req[s]),
        .cmd_o          (w_cmd[s]),
        .busy_o         (w_busy[s]),
        .stamp_o        (w_stamp[s])
      );
    end
  endgenerate

  // Merge stage write-backs; stages hitting one index share a single write
  always_comb begin
    stamp_in   = '0;
    stamp_flat = '0;
    take_in    = '0;
    take_flat  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      for (int s = 0; s < N_STAGE; s++) begin
        if (w_stamp[s].valid && (w_stamp[s].idx == SLOT_W'(i))) begin
          stamp_in[i]           = 1'b1;
          stamp_flat[i*3 +: 3] |= w_stamp[s].bits;
          if (s == STAMP_EX) begin
            take_in[i]                  = 1'b1;
            take_flat[i*TAKE_W +: TAKE_W] = w_stamp[s].take;
          end
        end
      end
    end
  end

  assign ex_req  = w_req[STAMP_EX];
  assign mem_req = w_req[STAMP_MEM];
  assign wb_req  = w_req[STAMP_WB];
  assign ex_cmd  = w_cmd[STAMP_EX];
  assign mem_cmd = w_cmd[STAMP_MEM];
  assign wb_cmd  = w_cmd[STAMP_WB];
  assign busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_stamp_dispatcher.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module    : tb_stamp_dispatcher                                         |
// | Purpose   : Directed per-cycle vector table plus a reset sequence for   |
// |             stamp_dispatcher.                                           |
// | Revision  : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
module tb_stamp_dispatcher;
  import conveyor_pkg::*;

  logic         clk;
  logic         reset;
  logic [23:0]  reg_start_flat;
  logic [703:0] reg_out_flat;
  logic         advance;
  logic         ex_req, mem_req, wb_req;
  logic [87:0]  ex_cmd, mem_cmd, wb_cmd;
  logic         ex_ack, mem_ack, wb_ack;
  logic         ex_done, mem_done, wb_done;
  logic [4:0]   ex_take;
  logic [23:0]  stamp_flat;
  logic [7:0]   stamp_in;
  logic [39:0]  take_flat;
  logic [7:0]   take_in;
  logic [2:0]   busy;

  stamp_dispatcher dut (
    .clk            (clk),
    .reset          (reset),
    .reg_start_flat (reg_start_flat),
    .reg_out_flat   (reg_out_flat),
    .advance        (advance),
    .ex_req         (ex_req),
    .mem_req        (mem_req),
    .wb_req         (wb_req),
    .ex_cmd         (ex_cmd),
    .mem_cmd        (mem_cmd),
    .wb_cmd         (wb_cmd),
    .ex_ack         (ex_ack),
    .mem_ack        (mem_ack),
    .wb_ack         (wb_ack),
    .ex_done        (ex_done),
    .mem_done       (mem_done),
    .wb_done        (wb_done),
    .ex_take        (ex_take),
    .stamp_flat     (stamp_flat),
    .stamp_in       (stamp_in),
    .take_flat      (take_flat),
    .take_in        (take_in),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs required during that cycle.
  // Stage 3-bit fields are {ex, mem, wb}.
  typedef struct {
    logic [23:0] rs;
    logic        adv;
    logic [2:0]  ack;
    logic [2:0]  done;
    logic [4:0]  take;
    logic [2:0]  e_req;
    logic [2:0]  e_busy;
    logic [7:0]  e_sin;
    logic [23:0] e_sflat;
    logic [7:0]  e_tin;
    logic [39:0] e_tflat;
    logic [2:0]  cmask;
    int          cslot;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          row    = -1;
  logic [87:0] slot_v [8];
  logic [2:0]  sbits  [8];
  vec_t        vecs   [$];

  function automatic vec_t mk(input logic [23:0] rs, input logic adv,
                              input logic [2:0] ack, input logic [2:0] done,
                              input logic [4:0] take, input logic [2:0] e_req,
                              input logic [2:0] e_busy, input logic [7:0] e_sin,
                              input logic [23:0] e_sflat, input logic [7:0] e_tin,
                              input logic [39:0] e_tflat, input logic [2:0] cmask,
                              input int cslot);
    vec_t v;
    v.rs = rs; v.adv = adv; v.ack = ack; v.done = done; v.take = take;
    v.e_req = e_req; v.e_busy = e_busy; v.e_sin = e_sin; v.e_sflat = e_sflat;
    v.e_tin = e_tin; v.e_tflat = e_tflat; v.cmask = cmask; v.cslot = cslot;
    return v;
  endfunction

  task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h required %h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_idle(input logic [23:0] rs, input logic adv, input logic [2:0] e_busy);
    vecs.push_back(mk(rs, adv, 3'b000, 3'b000, 5'h00, 3'b000, e_busy,
                      8'h00, 24'h0, 8'h00, 40'h0, 3'b000, 0));
  endtask

  initial begin
    reset          = 1'b1;
    reg_start_flat = '0;
    advance        = 1'b0;
    {ex_ack, mem_ack, wb_ack}    = 3'b000;
    {ex_done, mem_done, wb_done} = 3'b000;
    ex_take        = '0;

    // Slot contents: distinct byte pattern with the stamp bits in [2:0]
    sbits = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b011, 3'b001, 3'b000};
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      b = 8'h30 + 8'(k * 7);
      slot_v[k]      = {11{b}};
      slot_v[k][2:0] = sbits[k];
      reg_out_flat[k*88 +: 88] = slot_v[k];
    end

    // Exec on slot 5, ack at cycle 2, done with take 0A at cycle 4, no shift
    add_idle(24'h1 << 17, 1'b0, 3'b000);
    vecs.push_back(mk(24'h0, 0, 3'b000, 3'b000, 5'h00, 3'b100, 3'b100, 8'h00, 24'h0, 8'h00, 40'h0, 3'b100, 5));
    vecs.push_back(mk(24'h0, 0, 3'b100, 3'b000, 5'h00, 3'b100, 3'b100, 8'h00, 24'h0, 8'h00, 40'h0, 3'b100, 5));
    add_idle(24'h0, 1'b0, 3'b100);
    vecs.push_back(mk(24'h0, 0, 3'b000, 3'b100, 5'h0A, 3'b000, 3'b100, 8'h00, 24'h0, 8'h00, 40'h0, 3'b000, 0));
    vecs.push_back(mk(24'h0, 0, 3'b000, 3'b000, 5'h00, 3'b000, 3'b100, 8'h10, 24'h7 << 12, 8'h10, 40'h0A << 20, 3'b000, 0));
    add_idle(24'h0, 1'b0, 3'b000);

    // Mem ready on slots 6 and 2: slot 6 first (ack+done together), then slot 2
    add_idle((24'h1 << 19) | (24'h1 << 7), 1'b0, 3'b000);
    vecs.push_back(mk((24'h1 << 19) | (24'h1 << 7), 0, 3'b010, 3'b010, 5'h00, 3'b010, 3'b010, 8'h00, 24'h0, 8'h00, 40'h0, 3'b010, 6));
    vecs.push_back(mk(24'h1 << 7, 0, 3'b000, 3'b000, 5'h00, 3'b000, 3'b010, 8'h20, 24'h3 << 15, 8'h00, 40'h0, 3'b000, 0));
    add_idle(24'h1 << 7, 1'b0, 3'b000);
    vecs.push_back(mk(24'h0, 0, 3'b010, 3'b000, 5'h00, 3'b010, 3'b010, 8'h00, 24'h0, 8'h00, 40'h0, 3'b010, 2));
    vecs.push_back(mk(24'h0, 0, 3'b000, 3'b010, 5'h00, 3'b000, 3'b010, 8'h00, 24'h0, 8'h00, 40'h0, 3'b000, 0));
    vecs.push_back(mk(24'h0, 0, 3'b000, 3'b000, 5'h00, 3'b000, 3'b010, 8'h02, 24'h2 << 3, 8'h00, 40'h0, 3'b000, 0));
    add_idle(24'h0, 1'b0, 3'b000);

    // Exec on slot 3, two shifts during WAIT, stamp on a shifting cycle at cur=5
    add_idle(24'h1 << 11, 1'b0, 3'b000);
    vecs.push_back(mk(24'h0, 0, 3'b100, 3'b000, 5'h00, 3'b100, 3'b100, 8'h00, 24'h0, 8'h00, 40'h0, 3'b100, 3));
    add_idle(24'h0, 1'b1, 3'b100);
    add_idle(24'h0, 1'b1, 3'b100);
    vecs.push_back(mk(24'h0, 0, 3'b000, 3'b100, 5'h15, 3'b000, 3'b100, 8'h00, 24'h0, 8'h00, 40'h0, 3'b000, 0));
    vecs.push_back(mk(24'h0, 1, 3'b000, 3'b000, 5'h00, 3'b000, 3'b100, 8'h20, 24'h7 << 15, 8'h20, 40'h15 << 25, 3'b000, 0));
    add_idle(24'h0, 1'b0, 3'b000);

    // Wb on slot 0: stalled in STAMP for 3 cycles, stamps index 0 on first shift
    add_idle(24'h1, 1'b0, 3'b000);
    vecs.push_back(mk(24'h0, 0, 3'b001, 3'b001, 5'h00, 3'b001, 3'b001, 8'h00, 24'h0, 8'h00, 40'h0, 3'b001, 0));
    add_idle(24'h0, 1'b0, 3'b001);
    add_idle(24'h0, 1'b0, 3'b001);
    add_idle(24'h0, 1'b0, 3'b001);
    vecs.push_back(mk(24'h0, 1, 3'b000, 3'b000, 5'h00, 3'b000, 3'b001, 8'h01, 24'h3, 8'h00, 40'h0, 3'b000, 0));
    add_idle(24'h0, 1'b0, 3'b000);

    // Mem and wb on slot 4 complete together: one merged write at index 3
    add_idle(24'h3 << 12, 1'b0, 3'b000);
    vecs.push_back(mk(24'h0, 0, 3'b011, 3'b011, 5'h00, 3'b011, 3'b011, 8'h00, 24'h0, 8'h00, 40'h0, 3'b011, 4));
    vecs.push_back(mk(24'h0, 0, 3'b000, 3'b000, 5'h00, 3'b000, 3'b011, 8'h08, 24'h7 << 9, 8'h00, 40'h0, 3'b000, 0));
    add_idle(24'h0, 1'b0, 3'b000);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",        {85'h0, ex_req, mem_req, wb_req}, 88'h0);
    check("rst_busy",       {85'h0, busy}, 88'h0);
    check("rst_stamp_in",   {80'h0, stamp_in}, 88'h0);
    check("rst_take_in",    {80'h0, take_in}, 88'h0);
    check("rst_stamp_flat", {64'h0, stamp_flat}, 88'h0);
    check("rst_take_flat",  {48'h0, take_flat}, 88'h0);
    check("rst_ex_cmd",     ex_cmd, 88'h0);
    check("rst_mem_cmd",    mem_cmd, 88'h0);
    check("rst_wb_cmd",     wb_cmd, 88'h0);
    reset = 1'b0;

    // Table: apply each row, compare mid-cycle, then clock
    for (int r = 0; r < vecs.size(); r++) begin
      row            = r;
      reg_start_flat = vecs[r].rs;
      advance        = vecs[r].adv;
      {ex_ack, mem_ack, wb_ack}    = vecs[r].ack;
      {ex_done, mem_done, wb_done} = vecs[r].done;
      ex_take        = vecs[r].take;
      #1;
      check("req",        {85'h0, ex_req, mem_req, wb_req}, {85'h0, vecs[r].e_req});
      check("busy",       {85'h0, busy}, {85'h0, vecs[r].e_busy});
      check("stamp_in",   {80'h0, stamp_in}, {80'h0, vecs[r].e_sin});
      check("stamp_flat", {64'h0, stamp_flat}, {64'h0, vecs[r].e_sflat});
      check("take_in",    {80'h0, take_in}, {80'h0, vecs[r].e_tin});
      check("take_flat",  {48'h0, take_flat}, {48'h0, vecs[r].e_tflat});
      if (vecs[r].cmask[2]) check("ex_cmd",  ex_cmd,  slot_v[vecs[r].cslot]);
      if (vecs[r].cmask[1]) check("mem_cmd", mem_cmd, slot_v[vecs[r].cslot]);
      if (vecs[r].cmask[0]) check("wb_cmd",  wb_cmd,  slot_v[vecs[r].cslot]);
      step();
    end

    // Reset while exec waits for done; the late done must be ignored
    row = 1000;
    {ex_ack, mem_ack, wb_ack}    = 3'b000;
    {ex_done, mem_done, wb_done} = 3'b000;
    advance        = 1'b0;
    reg_start_flat = 24'h1 << 17;
    step();
    reg_start_flat = 24'h0;
    ex_ack         = 1'b1;
    #1;
    check("mid_ex_req", {87'h0, ex_req}, 88'h1);
    step();
    ex_ack = 1'b0;
    #1;
    check("mid_wait_busy", {85'h0, busy}, 88'h4);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",     {85'h0, busy}, 88'h0);
    check("mid_rst_ex_req",   {87'h0, ex_req}, 88'h0);
    check("mid_rst_stamp_in", {80'h0, stamp_in}, 88'h0);
    check("mid_rst_ex_cmd",   ex_cmd, 88'h0);
    step();
    reset   = 1'b0;
    ex_done = 1'b1;
    ex_take = 5'h1F;
    #1;
    check("late_done_stamp_in", {80'h0, stamp_in}, 88'h0);
    step();
    ex_done = 1'b0;
    #1;
    check("late_done_stamp_in2", {80'h0, stamp_in}, 88'h0);
    check("late_done_take_in",   {80'h0, take_in}, 88'h0);
    check("late_done_busy",      {85'h0, busy}, 88'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
